// File: rtl/lpc_host_arbiter_if.sv
// Bundles the requester, lpc_host control and response signals of the arbiter.
// Signal suffixes are named from the arbiter's point of view.
interface lpc_host_arbiter_if;
    logic        req0_valid_i;
    logic        req0_write_i;
    logic        req0_mem_i;
    logic [15:0] req0_addr_i;
    logic [7:0]  req0_data_i;
    logic        req0_ack_o;
    logic        req1_valid_i;
    logic        req1_write_i;
    logic        req1_mem_i;
    logic [15:0] req1_addr_i;
    logic [7:0]  req1_data_i;
    logic        req1_ack_o;
    logic [15:0] ctrl_addr_o;
    logic [7:0]  ctrl_data_o;
    logic        ctrl_lframe_o;
    logic        ctrl_rd_status_o;
    logic        ctrl_wr_status_o;
    logic        ctrl_memory_cycle_o;
    logic [7:0]  ctrl_data_i;
    logic        ctrl_ready_i;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic [2:0]  state_o;

    modport slave (
        input  req0_valid_i, req0_write_i, req0_mem_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_write_i, req1_mem_i, req1_addr_i, req1_data_i,
        input  ctrl_data_i, ctrl_ready_i,
        output req0_ack_o, req1_ack_o,
        output ctrl_addr_o, ctrl_data_o, ctrl_lframe_o, ctrl_rd_status_o,
        output ctrl_wr_status_o, ctrl_memory_cycle_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o, state_o
    );

    modport master (
        output req0_valid_i, req0_write_i, req0_mem_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_write_i, req1_mem_i, req1_addr_i, req1_data_i,
        output ctrl_data_i, ctrl_ready_i,
        input  req0_ack_o, req1_ack_o,
        input  ctrl_addr_o, ctrl_data_o, ctrl_lframe_o, ctrl_rd_status_o,
        input  ctrl_wr_status_o, ctrl_memory_cycle_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o, state_o
    );
endinterface

// File: rtl/lpc_host_arbiter.sv
// Round-robin arbiter sharing one lpc_host control port between two requesters.
// All control/response outputs are registered from the next-state decode.
module lpc_host_arbiter #(
    parameter int unsigned LFRAME_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    lpc_host_arbiter_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_e;

    localparam logic [15:0] LFRAME_LAST = 16'(LFRAME_CYCLES - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic        write_q, write_d;
    logic        mem_q, mem_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        lframe_q, lframe_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic        gnt_s;
    logic        active_s;

    // Next-state, request latching and next-output decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        write_d      = write_q;
        mem_d        = mem_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cnt_d        = cnt_q + 16'd1;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = 1'b0;
        rsp_data_d   = 8'h00;
        rsp_err_d    = 1'b0;
        gnt_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (bus.ctrl_ready_i && (bus.req0_valid_i || bus.req1_valid_i)) begin
                    // With both pending, the requester not served last wins.
                    if (bus.req0_valid_i && bus.req1_valid_i) begin
                        gnt_s = ~last_grant_q;
                    end else begin
                        gnt_s = bus.req1_valid_i;
                    end
                    ack0_d       = ~gnt_s;
                    ack1_d       = gnt_s;
                    id_d         = gnt_s;
                    last_grant_d = gnt_s;
                    write_d      = gnt_s ? bus.req1_write_i : bus.req0_write_i;
                    mem_d        = gnt_s ? bus.req1_mem_i   : bus.req0_mem_i;
                    addr_d       = gnt_s ? bus.req1_addr_i  : bus.req0_addr_i;
                    data_d       = gnt_s ? bus.req1_data_i  : bus.req0_data_i;
                    state_d      = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == LFRAME_LAST) begin
                    state_d = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WAIT_BUSY: begin
                if (cnt_q == TMO_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                end else if (!bus.ctrl_ready_i) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (cnt_q == TMO_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                end else if (bus.ctrl_ready_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = write_q ? 8'h00 : bus.ctrl_data_i;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_s = (state_d == ST_START) || (state_d == ST_WAIT_BUSY) ||
                   (state_d == ST_WAIT_DONE);
        lframe_d = (state_d != ST_START);
        rd_d     = active_s & ~write_d;
        wr_d     = active_s & write_d;
        busy_d   = (state_d != ST_IDLE);
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            write_q      <= 1'b0;
            mem_q        <= 1'b0;
            addr_q       <= 16'h0000;
            data_q       <= 8'h00;
            cnt_q        <= 16'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            lframe_q     <= 1'b1;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            write_q      <= write_d;
            mem_q        <= mem_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            lframe_q     <= lframe_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ack_o          = ack0_q;
    assign bus.req1_ack_o          = ack1_q;
    assign bus.ctrl_addr_o         = addr_q;
    assign bus.ctrl_data_o         = data_q;
    assign bus.ctrl_memory_cycle_o = mem_q;
    assign bus.ctrl_lframe_o       = lframe_q;
    assign bus.ctrl_rd_status_o    = rd_q;
    assign bus.ctrl_wr_status_o    = wr_q;
    assign bus.rsp_valid_o         = rsp_valid_q;
    assign bus.rsp_id_o            = rsp_id_q;
    assign bus.rsp_data_o          = rsp_data_q;
    assign bus.rsp_err_o           = rsp_err_q;
    assign bus.busy_o              = busy_q;
    assign bus.state_o             = state_q;
endmodule

// File: tb/tb_lpc_host_arbiter.sv
// Self-checking bench for lpc_host_arbiter: directed vector table, randomized
// transactions against a transaction-level model, and multi-cycle corner sequences.
module tb_lpc_host_arbiter;
    localparam int LF    = 2;
    localparam int TMO   = 256;
    localparam int TMO_T = 16;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    lpc_host_arbiter_if bus ();
    lpc_host_arbiter_if bus_t ();

    lpc_host_arbiter #(.LFRAME_CYCLES(LF), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i (clk), .nrst_i(nrst), .bus(bus));
    lpc_host_arbiter #(.LFRAME_CYCLES(LF), .TIMEOUT_CYCLES(TMO_T)) dut_t (
        .clk_i (clk), .nrst_i(nrst), .bus(bus_t));

    typedef struct {
        bit          id;
        bit          wr;
        bit          mem;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          d1;
        int          d2;
        logic [7:0]  rdata;
        bit          hang;
        logic [7:0]  exp_data;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int          dbl      = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.req0_ack_o && bus.req1_ack_o) dbl <= dbl + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input bit id, input bit v, input bit wr, input bit mem,
                             input logic [15:0] a, input logic [7:0] d);
        if (id) begin
            bus.req1_valid_i = v; bus.req1_write_i = wr; bus.req1_mem_i = mem;
            bus.req1_addr_i  = a; bus.req1_data_i  = d;
        end else begin
            bus.req0_valid_i = v; bus.req0_write_i = wr; bus.req0_mem_i = mem;
            bus.req0_addr_i  = a; bus.req0_data_i  = d;
        end
    endtask

    // Returns the acked requester, or -1 if no ack arrives within the budget.
    task automatic wait_ack(output int id);
        id = -1;
        for (int n = 0; n < 40 && id < 0; n++) begin
            tick();
            if (bus.req0_ack_o) id = 0;
            else if (bus.req1_ack_o) id = 1;
        end
    endtask

    // Host side of one transaction, entered on the first START cycle.
    task automatic serve(input int d1, input int d2, input logic [7:0] rdata, input bit hang,
                         output int lcnt, output int lat, output logic rid,
                         output logic [7:0] rdat, output logic rerr,
                         output logic [15:0] raddr, output logic [7:0] rwd,
                         output logic [1:0] rrw);
        int unsigned t0;
        t0   = cyc;
        lcnt = 0;
        while (bus.ctrl_lframe_o == 1'b0 && lcnt < 40) begin
            lcnt++;
            tick();
        end
        if (!hang) begin
            repeat (d1) tick();
            bus.ctrl_ready_i = 1'b0;
            repeat (d2) tick();
            bus.ctrl_data_i  = rdata;
            bus.ctrl_ready_i = 1'b1;
        end
        for (int n = 0; n < 400 && bus.rsp_valid_o !== 1'b1; n++) tick();
        lat   = int'(cyc - t0);
        rid   = bus.rsp_id_o;
        rdat  = bus.rsp_data_o;
        rerr  = bus.rsp_err_o;
        raddr = bus.ctrl_addr_o;
        rwd   = bus.ctrl_data_o;
        rrw   = {bus.ctrl_rd_status_o, bus.ctrl_wr_status_o};
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int id, lcnt, lat;
        logic rid, rerr;
        logic [7:0] rdat, rwd;
        logic [15:0] raddr;
        logic [1:0] rrw;
        drive_req(v.id, 1'b1, v.wr, v.mem, v.addr, v.wdata);
        wait_ack(id);
        // Scramble the request fields: only the ack-cycle values may be used.
        drive_req(v.id, 1'b0, ~v.wr, ~v.mem, ~v.addr, ~v.wdata);
        chk($sformatf("%s.ack_id", tag), 32'(id), 32'(v.id));
        chk($sformatf("%s.start_addr", tag), 32'(bus.ctrl_addr_o), 32'(v.addr));
        chk($sformatf("%s.start_wdata", tag), 32'(bus.ctrl_data_o), 32'(v.wdata));
        chk($sformatf("%s.mem", tag), 32'(bus.ctrl_memory_cycle_o), 32'(v.mem));
        chk($sformatf("%s.rdwr", tag), 32'({bus.ctrl_rd_status_o, bus.ctrl_wr_status_o}),
            32'({~v.wr, v.wr}));
        serve(v.d1, v.d2, v.rdata, v.hang, lcnt, lat, rid, rdat, rerr, raddr, rwd, rrw);
        chk($sformatf("%s.lframe_len", tag), 32'(lcnt), 32'(LF));
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("%s.rsp_id", tag), 32'(rid), 32'(v.id));
        chk($sformatf("%s.rsp_data", tag), 32'(rdat), 32'(v.exp_data));
        chk($sformatf("%s.rsp_err", tag), 32'(rerr), 32'(v.exp_err));
        chk($sformatf("%s.resp_addr", tag), 32'(raddr), 32'(v.addr));
        chk($sformatf("%s.resp_wdata", tag), 32'(rwd), 32'(v.wdata));
        chk($sformatf("%s.resp_rdwr", tag), 32'(rrw), 32'd0);
        tick();
        chk($sformatf("%s.idle_busy", tag), 32'(bus.busy_o), 32'd0);
        chk($sformatf("%s.idle_state", tag), 32'(bus.state_o), 32'd0);
    endtask

    vec_t tbl[5];

    initial begin
        int id, lcnt, lat, last, nack, rsp_cyc, rsp_seen;
        logic rid, rerr;
        logic [7:0] rdat, rwd;
        logic [15:0] raddr;
        logic [1:0] rrw;
        vec_t v;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 16'hF0F0, 8'h5A, 3, 10, 8'h33, 1'b0, 8'h00, 1'b0, 16};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h0080, 8'h00, 0, 1,  8'hA5, 1'b0, 8'hA5, 1'b0, 4};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1, 2,  8'h3C, 1'b0, 8'h3C, 1'b0, 6};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hFF, 2, 1,  8'h77, 1'b0, 8'h00, 1'b0, 6};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 0, 1,  8'h99, 1'b1, 8'h00, 1'b1, TMO};

        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        bus.ctrl_ready_i   = 1'b1;
        bus.ctrl_data_i    = 8'h00;
        bus_t.req0_valid_i = 1'b0; bus_t.req0_write_i = 1'b0; bus_t.req0_mem_i = 1'b0;
        bus_t.req0_addr_i  = 16'h0000; bus_t.req0_data_i = 8'h00;
        bus_t.req1_valid_i = 1'b0; bus_t.req1_write_i = 1'b0; bus_t.req1_mem_i = 1'b0;
        bus_t.req1_addr_i  = 16'h0000; bus_t.req1_data_i = 8'h00;
        bus_t.ctrl_ready_i = 1'b1;
        bus_t.ctrl_data_i  = 8'h00;

        repeat (2) tick();
        chk("reset.lframe", 32'(bus.ctrl_lframe_o), 32'd1);
        chk("reset.busy", 32'(bus.busy_o), 32'd0);
        chk("reset.state", 32'(bus.state_o), 32'd0);
        chk("reset.outs", 32'({bus.req0_ack_o, bus.req1_ack_o, bus.rsp_valid_o, bus.rsp_err_o,
                              bus.ctrl_rd_status_o, bus.ctrl_wr_status_o}), 32'd0);
        chk("reset.addr", 32'(bus.ctrl_addr_o), 32'd0);
        nrst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_one(tbl[i], $sformatf("vec%0d", i));

        // Randomized transactions against the transaction-level model.
        for (int i = 0; i < 24; i++) begin
            v.id    = 1'($urandom_range(0, 1));
            v.wr    = 1'($urandom_range(0, 1));
            v.mem   = 1'($urandom_range(0, 1));
            v.addr  = 16'($urandom);
            v.wdata = 8'($urandom);
            v.d1    = int'($urandom_range(0, 3));
            v.d2    = int'($urandom_range(1, 5));
            v.rdata = 8'($urandom);
            v.hang  = ($urandom_range(0, 11) == 0);
            v.exp_data = (v.wr || v.hang) ? 8'h00 : v.rdata;
            v.exp_err  = v.hang;
            v.exp_lat  = v.hang ? TMO : LF + v.d1 + v.d2 + 1;
            run_one(v, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Host busy when the request arrives: no ack until ready returns.
        bus.ctrl_ready_i = 1'b0;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h4242, 8'h00);
        nack = 0;
        repeat (4) begin
            tick();
            if (bus.req0_ack_o || bus.req1_ack_o) nack++;
        end
        chk("hostbusy.no_ack", 32'(nack), 32'd0);
        bus.ctrl_ready_i = 1'b1;
        tick();
        chk("hostbusy.ack_first", 32'(bus.req0_ack_o), 32'd1);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        serve(0, 1, 8'h6E, 1'b0, lcnt, lat, rid, rdat, rerr, raddr, rwd, rrw);
        chk("hostbusy.rsp_data", 32'(rdat), 32'h6E);
        tick();

        // Reset while in WAIT_DONE: abort with no response.
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 8'h00);
        wait_ack(id);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        for (int n = 0; n < 20 && bus.ctrl_lframe_o == 1'b0; n++) tick();
        bus.ctrl_ready_i = 1'b0;
        repeat (2) tick();
        chk("rstmid.in_wait_done", 32'(bus.state_o), 32'd3);
        #1 nrst = 1'b0;
        #1;
        chk("rstmid.lframe", 32'(bus.ctrl_lframe_o), 32'd1);
        chk("rstmid.busy", 32'(bus.busy_o), 32'd0);
        chk("rstmid.state", 32'(bus.state_o), 32'd0);
        rsp_seen = 0;
        repeat (3) begin
            tick();
            if (bus.rsp_valid_o) rsp_seen++;
        end
        chk("rstmid.no_rsp", 32'(rsp_seen), 32'd0);
        bus.ctrl_ready_i = 1'b1;
        nrst = 1'b1;

        // Contention straight after reset: grants alternate starting with 0.
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 16'hA000, 8'h00);
        drive_req(1'b1, 1'b1, 1'b0, 1'b0, 16'hB001, 8'h00);
        last    = 1;
        rsp_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(id);
            chk($sformatf("contend%0d.grant", k), 32'(id), 32'(1 - last));
            chk($sformatf("contend%0d.addr", k), 32'(bus.ctrl_addr_o),
                (id == 1) ? 32'hB001 : 32'hA000);
            if (k > 0) chk($sformatf("contend%0d.b2b_gap", k), cyc - 32'(rsp_cyc), 32'd2);
            last = (id == 1) ? 1 : 0;
            serve(0, 1, 8'(8'h10 + k), 1'b0, lcnt, lat, rid, rdat, rerr, raddr, rwd, rrw);
            rsp_cyc = int'(cyc);
            chk($sformatf("contend%0d.rsp_id", k), 32'(rid), 32'(last));
            chk($sformatf("contend%0d.rsp_data", k), 32'(rdat), 32'(8'h10 + k));
            if (k == 3) begin
                drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
                drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
            end
        end
        repeat (3) tick();
        chk("contend.no_double_ack", 32'(dbl), 32'd0);
        chk("contend.idle_after", 32'(bus.state_o), 32'd0);

        // Timeout with ready stuck high, on the instance with a 16-clock limit.
        bus_t.req0_valid_i = 1'b1;
        bus_t.req0_addr_i  = 16'h0C0C;
        id = -1;
        for (int n = 0; n < 40 && id < 0; n++) begin
            tick();
            if (bus_t.req0_ack_o) id = 0;
        end
        bus_t.req0_valid_i = 1'b0;
        chk("tmo.ack", 32'(id), 32'd0);
        rsp_cyc = int'(cyc);
        for (int n = 0; n < 100 && bus_t.rsp_valid_o !== 1'b1; n++) tick();
        chk("tmo.latency", cyc - 32'(rsp_cyc), 32'(TMO_T));
        chk("tmo.err", 32'(bus_t.rsp_err_o), 32'd1);
        chk("tmo.data", 32'(bus_t.rsp_data_o), 32'd0);
        chk("tmo.valid", 32'(bus_t.rsp_valid_o), 32'd1);
        tick();
        chk("tmo.idle_state", 32'(bus_t.state_o), 32'd0);
        chk("tmo.idle_busy", 32'(bus_t.busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lpc_host_arbiter.md
Name: lpc_host_arbiter

Overview:
- Shares one lpc_host control port between two independent requesters, e.g. a GPIO/bridge front end and an internal scan engine.
- Arbitrates round-robin and latches the winning request.
- Sequences the host's frame-start, rd/wr and memory-cycle controls, then waits on the host ready handshake.
- Returns read data and completion or timeout status on a shared response bus tagged with the requester id.

Parameters:
- LFRAME_CYCLES, 2, number of clocks ctrl_lframe_o is held low per transaction (1..15).
- TIMEOUT_CYCLES, 256, clocks allowed from frame start to host ready returning high before an error is reported (16..65535).

Ports:
- clk_i  input  1  clock; also clocks the lpc_host control side.
- nrst_i  input  1  asynchronous active-low reset.
- req0_valid_i  input  1  requester 0 has a transaction; held until req0_ack_o.
- req0_write_i  input  1  1 = write, 0 = read.
- req0_mem_i  input  1  1 = memory cycle, 0 = I/O cycle.
- req0_addr_i  input  16  LPC address.
- req0_data_i  input  8  write data.
- req0_ack_o  output  1  one-clock pulse when the request is latched.
- req1_valid_i, req1_write_i, req1_mem_i, req1_addr_i, req1_data_i, req1_ack_o  same as requester 0.
- ctrl_addr_o  output  16  to lpc_host ctrl_addr_i.
- ctrl_data_o  output  8  to lpc_host ctrl_data_i.
- ctrl_lframe_o  output  1  to lpc_host ctrl_lframe_i; active low.
- ctrl_rd_status_o  output  1  to ctrl_rd_status_i.
- ctrl_wr_status_o  output  1  to ctrl_wr_status_i.
- ctrl_memory_cycle_o  output  1  to ctrl_memory_cycle_i.
- ctrl_data_i  input  8  from lpc_host ctrl_data_o.
- ctrl_ready_i  input  1  from lpc_host ctrl_ready_o; high = host idle.
- rsp_valid_o  output  1  one-clock completion pulse.
- rsp_id_o  output  1  requester owning the response.
- rsp_data_o  output  8  read data; 0x00 for writes or on error.
- rsp_err_o  output  1  timeout flag, valid with rsp_valid_o.
- busy_o  output  1  high in every state except IDLE.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- Reset values (asynchronous, nrst_i low):
  - ctrl_lframe_o = 1; all other outputs = 0.
  - State = IDLE; last_grant = 1, so requester 0 wins first.
  - Internal latches and counters = 0.
- State encodings: IDLE = 0, START = 1, WAIT_BUSY = 2, WAIT_DONE = 3, RESP = 4.
- IDLE:
  - Grants only when ctrl_ready_i = 1 and at least one valid is high.
  - If both valids are high, grant goes to the requester that is not last_grant. Otherwise grant goes to the single valid requester.
  - On grant: ack pulses for one clock; addr, data, write, mem and id are latched; last_grant is updated; next state is START.
  - Requester inputs are sampled only on the ack cycle.
- START:
  - ctrl_lframe_o = 0 for exactly LFRAME_CYCLES clocks.
  - ctrl_addr_o, ctrl_data_o and ctrl_memory_cycle_o are driven from the latches. They stay stable from START entry until RESP exits.
  - ctrl_wr_status_o = write and ctrl_rd_status_o = ~write, both asserted from START entry through WAIT_DONE.
  - ctrl_lframe_o returns to 1 on leaving START. Next state is WAIT_BUSY.
- Timeout counter:
  - Clears on START entry and increments every clock in START, WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE forces RESP with the error flag set.
- WAIT_BUSY: waits for ctrl_ready_i = 0 (host accepted the frame), then goes to WAIT_DONE.
- WAIT_DONE: waits for ctrl_ready_i = 1. On that clock, for a read, ctrl_data_i is captured. Next state is RESP.
- RESP:
  - Lasts one clock. rsp_valid_o = 1; rsp_id_o = latched id; rsp_data_o = captured data (read, no error) or 0x00.
  - rsp_err_o = 1 only on timeout.
  - rd/wr status drop to 0. Next state is IDLE.
- Latency:
  - From ack, a zero-wait host gives START (LFRAME_CYCLES) + WAIT_BUSY (≥1) + WAIT_DONE (≥1) + RESP (1).
  - Back-to-back grants are possible the clock after RESP.
- Simultaneous events:
  - A valid rising during a transaction is held off, with no ack, until IDLE.
  - ctrl_ready_i dropping and returning within one clock while in WAIT_BUSY is not detected and ends in timeout. This is documented behaviour.
- Reset mid-transaction aborts immediately to reset values with no response pulse. The requester must reissue.
- Only one requester is acked per clock. Starvation is impossible: with both valids held continuously, grants alternate 0,1,0,1.

Test Plan:
- Single write: req0 write, addr 0xF0F0, data 0x5A, mem 0; host ready drops 3 clocks after the frame and returns 10 clocks later. Required: ack0 pulse; ctrl_lframe_o low exactly 2 clocks; ctrl_addr_o = 0xF0F0 and ctrl_data_o = 0x5A stable through WAIT_DONE; one rsp_valid_o with id = 0, data = 0x00, err = 0.
- Single read: req1 read, addr 0x0080, mem 1; ctrl_data_i = 0xA5 when ready returns. Required: ctrl_rd_status_o = 1 and ctrl_memory_cycle_o = 1; rsp_data_o = 0xA5, rsp_id_o = 1.
- Contention: both valids held high for 4 transactions. Required: grants in order 0,1,0,1; no double ack in any clock.
- Timeout: ctrl_ready_i stuck at 1 after the frame, TIMEOUT_CYCLES = 16. Required: rsp_valid_o with rsp_err_o = 1 and rsp_data_o = 0x00 exactly 16 clocks after START entry; back in IDLE next clock.
- Host busy at request: ctrl_ready_i = 0 while req0_valid_i rises. Required: no ack until ready = 1; ack on the first clock with ready = 1.
- Reset mid-operation: assert nrst_i low in WAIT_DONE. Required: ctrl_lframe_o = 1, busy_o = 0, no rsp_valid_o; after release, the next req0 is acked before req1 if both are valid.
